// File: rtl/xgmii_tlp_rx_pkg.sv
// Shared tags, XGMII constants, FSM states and TLP length arithmetic for the
// XGMII PCIe-over-UDP receive engine.
package xgmii_tlp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_TLP1,
    ST_TLP2,
    ST_SKIP,
    ST_GAP
  } state_e;

  localparam logic [7:0] TAG_START   = 8'h0D;
  localparam logic [7:0] TAG_MID     = 8'h0C;
  localparam logic [7:0] TAG_END2    = 8'h0E;
  localparam logic [7:0] TAG_END1    = 8'h06;
  localparam logic [7:0] TAG_ABORT   = 8'h10;
  localparam logic [7:0] XGMII_START = 8'hFB;

  localparam int unsigned N_CNT      = 5;
  localparam int unsigned CNT_FRAMES = 0;
  localparam int unsigned CNT_ACCEPT = 1;
  localparam int unsigned CNT_FILT   = 2;
  localparam int unsigned CNT_FULL   = 3;
  localparam int unsigned CNT_ABORT  = 4;

  // DWs still to come after the 2-DW start word; a zero Length field means 1024
  function automatic logic [10:0] tlp_rem(input logic has_data,
                                          input logic hdr_4dw,
                                          input logic [9:0] len);
    logic [10:0] l;
    logic [10:0] tot;
    l   = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    tot = 11'd3 + {10'd0, hdr_4dw} + (has_data ? l : 11'd0);
    return tot - 11'd2;
  endfunction

endpackage

// File: rtl/xgmii_tlp_rx_align.sv
// Lane-4 start realignment: splices the previous upper half under the current
// lower half so lane 0 of the output is always the first byte of the frame.
module xgmii_lane_align (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        align_i,
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic [63:0] rxd_o,
  output logic [7:0]  rxc_o
);

  logic [31:0] prev_dat_q;
  logic [3:0]  prev_ctl_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_dat_q <= '0;
      prev_ctl_q <= '0;
    end else begin
      prev_dat_q <= rxd_i[63:32];
      prev_ctl_q <= rxc_i[7:4];
    end
  end

  always_comb begin
    if (align_i) begin
      rxd_o = {rxd_i[31:0], prev_dat_q};
      rxc_o = {rxc_i[3:0], prev_ctl_q};
    end else begin
      rxd_o = rxd_i;
      rxc_o = rxc_i;
    end
  end

endmodule

// File: rtl/xgmii_tlp_rx.sv
// XGMII receive engine: filters UDP-tunnelled frames and writes the carried
// PCIe TLPs as tagged 72-bit words into the downstream FIFO.
module xgmii_tlp_rx
  import xgmii_tlp_pkg::*;
#(
  parameter logic [15:0] UDP_PORT  = 16'd3422,
  parameter logic [31:0] MAGIC     = 32'h4950_4E41,
  parameter logic [3:0]  GAP       = 4'h5,
  parameter bit          CHECK_DST = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             xgmii_clk,
  input  logic             sys_rst,
  input  logic [7:0]       xgmii_rxc,
  input  logic [63:0]      xgmii_rxd,
  input  logic [47:0]      if_macaddr,
  input  logic [31:0]      if_v4addr,
  input  logic             prog_full,
  output logic [71:0]      din,
  output logic             wr_en,
  output logic [CNT_W-1:0] cnt_frames,
  output logic [CNT_W-1:0] cnt_accept,
  output logic [CNT_W-1:0] cnt_filt,
  output logic [CNT_W-1:0] cnt_full,
  output logic [CNT_W-1:0] cnt_abort,
  output logic [7:0]       tlp_count
);

  state_e      state_q, state_d;
  logic        align_q, align_d;
  logic        pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic        ok_q, ok_d;
  logic [10:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic [71:0] din_q, din_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  tlp_q;
  logic        tlp_inc;
  logic [N_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_q [N_CNT];

  logic [63:0] ad;
  logic [7:0]  ac;
  logic        sop0, sop4, anyc, field_ok;
  logic [10:0] rem_new;

  xgmii_lane_align u_align (
    .clk_i   (xgmii_clk),
    .rst_i   (sys_rst),
    .align_i (align_q),
    .rxd_i   (xgmii_rxd),
    .rxc_i   (xgmii_rxc),
    .rxd_o   (ad),
    .rxc_o   (ac)
  );

  // Per-word header field check on the aligned stream; wire order is big-endian
  always_comb begin
    sop0     = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
    sop4     = xgmii_rxc[4] && (xgmii_rxd[39:32] == XGMII_START);
    anyc     = |ac;
    rem_new  = tlp_rem(ad[30], ad[29], ad[9:0]);
    field_ok = 1'b1;
    unique case (idx_q)
      3'd0: if (CHECK_DST)
              field_ok = {ad[7:0], ad[15:8], ad[23:16], ad[31:24], ad[39:32], ad[47:40]}
                         == if_macaddr;
      3'd1: field_ok = {ad[39:32], ad[47:40]} == 16'h0800;
      3'd2: field_ok = ad[63:56] == 8'h11;
      3'd3: if (CHECK_DST) field_ok = {ad[55:48], ad[63:56]} == if_v4addr[31:16];
      3'd4: field_ok = ({ad[39:32], ad[47:40]} == UDP_PORT) &&
                       (!CHECK_DST || ({ad[7:0], ad[15:8]} == if_v4addr[15:0]));
      3'd5: field_ok = {ad[23:16], ad[31:24], ad[39:32], ad[47:40]} == MAGIC;
      default: field_ok = 1'b1;
    endcase
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      align_q <= 1'b0;
      pre_q   <= 1'b0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      rem_q   <= '0;
      gap_q   <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      tlp_q   <= '0;
      for (int unsigned i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      align_q <= align_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
      if (tlp_inc) tlp_q <= tlp_q + 8'd1;
      for (int unsigned i = 0; i < N_CNT; i++)
        if (cnt_inc[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  // pre_q skips the aligned preamble word that a lane-4 start produces
  always_comb begin
    state_d = state_q;
    align_d = align_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sop0 || sop4) begin
          state_d = ST_HEAD;
          align_d = !sop0;
          pre_d   = !sop0;
          idx_d   = '0;
          ok_d    = 1'b1;
        end
      end
      ST_HEAD: begin
        if (pre_q) begin
          pre_d = 1'b0;
        end else if (anyc) begin
          state_d = ST_IDLE;
          align_d = 1'b0;
        end else if (idx_q == 3'd5) begin
          state_d = (!(ok_q && field_ok) || prog_full) ? ST_SKIP : ST_TLP1;
        end else begin
          idx_d = idx_q + 3'd1;
          ok_d  = ok_q && field_ok;
        end
      end
      ST_TLP1: begin
        if (anyc) begin
          state_d = ST_GAP;
          gap_d   = GAP;
        end else if (rem_new != '0) begin
          state_d = ST_TLP2;
          rem_d   = rem_new;
        end
      end
      ST_TLP2: begin
        if (anyc) begin
          state_d = ST_GAP;
          gap_d   = GAP;
        end else if (rem_q == 11'd2 || rem_q == 11'd1) begin
          state_d = ST_TLP1;
        end else begin
          rem_d = rem_q - 11'd2;
        end
      end
      ST_SKIP: begin
        if (anyc) begin
          state_d = ST_IDLE;
          align_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          align_d = 1'b0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        align_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    din_d   = '0;
    wr_en_d = 1'b0;
    cnt_inc = '0;
    tlp_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: if (sop0 || sop4) cnt_inc[CNT_FRAMES] = 1'b1;
      ST_HEAD: begin
        if (!pre_q) begin
          if (anyc) cnt_inc[CNT_FILT] = 1'b1;
          else if (idx_q == 3'd5) begin
            if (!(ok_q && field_ok)) cnt_inc[CNT_FILT]   = 1'b1;
            else if (prog_full)      cnt_inc[CNT_FULL]   = 1'b1;
            else                     cnt_inc[CNT_ACCEPT] = 1'b1;
          end
        end
      end
      ST_TLP1: begin
        if (!anyc) begin
          wr_en_d = 1'b1;
          if (rem_new == '0) begin
            din_d   = {TAG_END2, ad};
            tlp_inc = 1'b1;
          end else begin
            din_d = {TAG_START, ad};
          end
        end
      end
      ST_TLP2: begin
        wr_en_d = 1'b1;
        if (anyc) begin
          din_d              = {TAG_ABORT, 64'h0};
          cnt_inc[CNT_ABORT] = 1'b1;
        end else if (rem_q == 11'd2) begin
          din_d   = {TAG_END2, ad};
          tlp_inc = 1'b1;
        end else if (rem_q == 11'd1) begin
          din_d   = {TAG_END1, ad};
          tlp_inc = 1'b1;
        end else begin
          din_d = {TAG_MID, ad};
        end
      end
      ST_GAP:  wr_en_d = 1'b1;
      default: wr_en_d = 1'b0;
    endcase
  end

  assign din        = din_q;
  assign wr_en      = wr_en_q;
  assign tlp_count  = tlp_q;
  assign cnt_frames = cnt_q[CNT_FRAMES];
  assign cnt_accept = cnt_q[CNT_ACCEPT];
  assign cnt_filt   = cnt_q[CNT_FILT];
  assign cnt_full   = cnt_q[CNT_FULL];
  assign cnt_abort  = cnt_q[CNT_ABORT];

endmodule

// File: tb/tb_xgmii_tlp_rx.sv
// Directed bench for xgmii_tlp_rx: a table of frame scenarios with expected
// FIFO tag sequences and counter totals, plus runt, saturation and reset cases.
module tb_xgmii_tlp_rx;

  localparam logic [47:0] MAC    = 48'h02_11_22_33_44_55;
  localparam logic [31:0] IP     = 32'hC0A8_0107;
  localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
  localparam logic [63:0] TERM_D = 64'h0707_0707_0707_07FD;
  localparam logic [63:0] PRE_D  = 64'hD555_5555_5555_55FB;

  localparam int unsigned B_NONE = 0, B_MAC = 1, B_IP = 2, B_PORT = 3,
                          B_MAGIC = 4, B_ETYPE = 5, B_PROTO = 6;
  localparam int unsigned P_MWR = 0, P_TWO = 1, P_ABT = 2;
  localparam int unsigned S_NONE = 0, S_MWR = 1, S_TWO = 2, S_ABT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rxc = 8'hFF;
  logic [63:0] rxd = IDLE_D;
  logic        pf  = 1'b0;
  logic [71:0] din, din_s;
  logic        wr_en, wr_en_s;
  logic [15:0] c_frames, c_accept, c_filt, c_full, c_abort;
  logic [1:0]  s_frames, s_accept, s_filt, s_full, s_abort;
  logic [7:0]  tlp_cnt, tlp_cnt_s;

  always #5 clk = ~clk;

  xgmii_tlp_rx #(.UDP_PORT(16'd3422), .MAGIC(32'h4950_4E41), .GAP(4'h5),
                 .CHECK_DST(1'b1), .CNT_W(16)) dut (
    .xgmii_clk(clk), .sys_rst(rst), .xgmii_rxc(rxc), .xgmii_rxd(rxd),
    .if_macaddr(MAC), .if_v4addr(IP), .prog_full(pf),
    .din(din), .wr_en(wr_en), .cnt_frames(c_frames), .cnt_accept(c_accept),
    .cnt_filt(c_filt), .cnt_full(c_full), .cnt_abort(c_abort), .tlp_count(tlp_cnt)
  );

  xgmii_tlp_rx #(.UDP_PORT(16'd3422), .MAGIC(32'h4950_4E41), .GAP(4'h5),
                 .CHECK_DST(1'b1), .CNT_W(2)) dut_s (
    .xgmii_clk(clk), .sys_rst(rst), .xgmii_rxc(rxc), .xgmii_rxd(rxd),
    .if_macaddr(MAC), .if_v4addr(IP), .prog_full(pf),
    .din(din_s), .wr_en(wr_en_s), .cnt_frames(s_frames), .cnt_accept(s_accept),
    .cnt_filt(s_filt), .cnt_full(s_full), .cnt_abort(s_abort), .tlp_count(tlp_cnt_s)
  );

  typedef struct { logic [63:0] d; logic [7:0] c; } xw_t;
  typedef struct {
    bit lane4; int unsigned bad; int unsigned pat; bit pf; int unsigned seq;
    int unsigned ef, ea, efi, efu, eab, et;
  } vec_t;

  xw_t         aq[$];
  logic [71:0] wq[$];
  int          ws[$];
  int          n_step = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq.push_back(din);
      ws.push_back(n_step - 1);
    end
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned tlp_len(input int unsigned pat);
    case (pat)
      P_MWR:   return 3;
      P_TWO:   return 5;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] tlpw(input int unsigned pat, input int unsigned i);
    logic [63:0] w;
    w = '0;
    case (pat)
      P_MWR: case (i)
        0: w = {32'h0000_00FF, 32'h4000_0002};
        1: w = {32'hCAFE_0001, 32'h1000_0000};
        default: w = {32'h0000_0000, 32'hDEAD_BEEF};
      endcase
      P_TWO: case (i)
        0: w = {32'h0000_0001, 32'h2000_0001};
        1: w = {32'h3333_4444, 32'h1111_2222};
        2: w = {32'h0000_0040, 32'h6000_0001};
        3: w = {32'hAAAA_0000, 32'h0000_0000};
        default: w = {32'h0000_0000, 32'h1234_5678};
      endcase
      default: w = {32'h0000_0000, 32'h4000_0005};
    endcase
    return w;
  endfunction

  function automatic int unsigned seq_len(input int unsigned seq);
    case (seq)
      S_MWR:   return 9;
      S_TWO:   return 11;
      S_ABT:   return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] seq_tag(input int unsigned seq, input int unsigned i);
    logic [7:0] t;
    t = 8'h00;
    case (seq)
      S_MWR: case (i) 0: t = 8'h0D; 1: t = 8'h0C; 2: t = 8'h06; default: t = 8'h00; endcase
      S_TWO: case (i)
        0: t = 8'h0D; 1: t = 8'h0E; 2: t = 8'h0D; 3: t = 8'h0C; 4: t = 8'h06;
        default: t = 8'h00;
      endcase
      S_ABT: case (i) 0: t = 8'h0D; 1: t = 8'h10; default: t = 8'h00; endcase
      default: t = 8'h00;
    endcase
    return t;
  endfunction

  task automatic build(input int unsigned bad, input int unsigned pat);
    logic [7:0]  b [48];
    logic [47:0] mac;
    logic [31:0] ip, mg;
    logic [15:0] port, et;
    logic [7:0]  pr;
    xw_t         w;
    mac  = (bad == B_MAC)   ? (MAC ^ 48'h1) : MAC;
    ip   = (bad == B_IP)    ? (IP ^ 32'h100) : IP;
    port = (bad == B_PORT)  ? 16'd3423 : 16'd3422;
    mg   = (bad == B_MAGIC) ? 32'h4950_4E42 : 32'h4950_4E41;
    et   = (bad == B_ETYPE) ? 16'h86DD : 16'h0800;
    pr   = (bad == B_PROTO) ? 8'h06 : 8'h11;
    for (int unsigned i = 0; i < 48; i++) b[i] = 8'h00;
    for (int unsigned i = 0; i < 6; i++) begin
      b[i]     = mac[47-8*i -: 8];
      b[6 + i] = 8'hA6;
    end
    b[12] = et[15:8];
    b[13] = et[7:0];
    b[14] = 8'h45;
    b[23] = pr;
    for (int unsigned i = 0; i < 4; i++) begin
      b[30 + i] = ip[31-8*i -: 8];
      b[42 + i] = mg[31-8*i -: 8];
    end
    b[36] = port[15:8];
    b[37] = port[7:0];
    aq.delete();
    w.d = PRE_D; w.c = 8'h01; aq.push_back(w);
    for (int unsigned k = 0; k < 6; k++) begin
      w.c = 8'h00;
      for (int unsigned j = 0; j < 8; j++) w.d[8*j +: 8] = b[8*k + j];
      aq.push_back(w);
    end
    for (int unsigned i = 0; i < tlp_len(pat); i++) begin
      w.d = tlpw(pat, i); w.c = 8'h00; aq.push_back(w);
    end
    w.d = TERM_D; w.c = 8'hFF; aq.push_back(w);
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    rxd = d;
    rxc = c;
    @(posedge clk);
    #1;
    n_step++;
  endtask

  // Lane-4 stream: raw(k) carries aligned(k) low half in its upper lanes
  task automatic send(input bit lane4, input bit pfv, output int f);
    xw_t lo, hi;
    f  = n_step;
    pf = pfv;
    if (!lane4) begin
      foreach (aq[k]) step(aq[k].d, aq[k].c);
    end else begin
      for (int k = 0; k <= aq.size(); k++) begin
        if (k < aq.size()) lo = aq[k]; else begin lo.d = IDLE_D; lo.c = 8'hFF; end
        if (k > 0) hi = aq[k-1]; else begin hi.d = IDLE_D; hi.c = 8'hFF; end
        step({lo.d[31:0], hi.d[63:32]}, {lo.c[3:0], hi.c[7:4]});
      end
    end
    for (int i = 0; i < 12; i++) step(IDLE_D, 8'hFF);
    pf = 1'b0;
  endtask

  task automatic check_writes(input int unsigned pat, input int unsigned seq,
                              input bit lane4, input int f);
    int unsigned p;
    logic [7:0]  t;
    logic [63:0] d;
    p = 0;
    chk("nwrites", 72'(wq.size()), 72'(seq_len(seq)));
    for (int unsigned i = 0; i < seq_len(seq) && i < wq.size(); i++) begin
      t = seq_tag(seq, i);
      d = '0;
      if (t == 8'h0D || t == 8'h0C || t == 8'h0E || t == 8'h06) begin
        d = tlpw(pat, p);
        p++;
      end
      chk($sformatf("word%0d", i), wq[i], {t, d});
    end
    if (seq_len(seq) > 0 && ws.size() > 0)
      chk("latency", 72'(ws[0] - f), lane4 ? 72'd8 : 72'd7);
  endtask

  vec_t vt [13];
  int   f;

  initial begin
    vt[0]  = '{1'b0, B_NONE,  P_MWR, 1'b0, S_MWR,   1, 1, 0, 0, 0, 1};
    vt[1]  = '{1'b1, B_NONE,  P_MWR, 1'b0, S_MWR,   2, 2, 0, 0, 0, 2};
    vt[2]  = '{1'b0, B_PORT,  P_MWR, 1'b0, S_NONE,  3, 2, 1, 0, 0, 2};
    vt[3]  = '{1'b0, B_MAC,   P_MWR, 1'b0, S_NONE,  4, 2, 2, 0, 0, 2};
    vt[4]  = '{1'b0, B_NONE,  P_MWR, 1'b1, S_NONE,  5, 2, 2, 1, 0, 2};
    vt[5]  = '{1'b0, B_NONE,  P_MWR, 1'b0, S_MWR,   6, 3, 2, 1, 0, 3};
    vt[6]  = '{1'b1, B_NONE,  P_TWO, 1'b0, S_TWO,   7, 4, 2, 1, 0, 5};
    vt[7]  = '{1'b0, B_NONE,  P_ABT, 1'b0, S_ABT,   8, 5, 2, 1, 1, 5};
    vt[8]  = '{1'b1, B_MAGIC, P_MWR, 1'b0, S_NONE,  9, 5, 3, 1, 1, 5};
    vt[9]  = '{1'b0, B_IP,    P_MWR, 1'b0, S_NONE, 10, 5, 4, 1, 1, 5};
    vt[10] = '{1'b0, B_ETYPE, P_TWO, 1'b0, S_NONE, 11, 5, 5, 1, 1, 5};
    vt[11] = '{1'b1, B_PROTO, P_MWR, 1'b0, S_NONE, 12, 5, 6, 1, 1, 5};
    vt[12] = '{1'b1, B_NONE,  P_ABT, 1'b0, S_ABT,  13, 6, 6, 1, 2, 5};

    for (int i = 0; i < 3; i++) step(IDLE_D, 8'hFF);
    chk("rst_wr_en", 72'(wr_en), 72'd0);
    chk("rst_din", din, 72'd0);
    chk("rst_frames", 72'(c_frames), 72'd0);
    chk("rst_accept", 72'(c_accept), 72'd0);
    chk("rst_tlp", 72'(tlp_cnt), 72'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) step(IDLE_D, 8'hFF);

    foreach (vt[i]) begin
      build(vt[i].bad, vt[i].pat);
      wq.delete();
      ws.delete();
      send(vt[i].lane4, vt[i].pf, f);
      check_writes(vt[i].pat, vt[i].seq, vt[i].lane4, f);
      chk($sformatf("v%0d_frames", i), 72'(c_frames), 72'(vt[i].ef));
      chk($sformatf("v%0d_accept", i), 72'(c_accept), 72'(vt[i].ea));
      chk($sformatf("v%0d_filt", i),   72'(c_filt),   72'(vt[i].efi));
      chk($sformatf("v%0d_full", i),   72'(c_full),   72'(vt[i].efu));
      chk($sformatf("v%0d_abort", i),  72'(c_abort),  72'(vt[i].eab));
      chk($sformatf("v%0d_tlp", i),    72'(tlp_cnt),  72'(vt[i].et));
    end

    // Runt: control character arrives at w2
    build(B_NONE, P_MWR);
    aq = aq[0:2];
    aq.push_back('{TERM_D, 8'hFF});
    wq.delete();
    ws.delete();
    send(1'b0, 1'b0, f);
    chk("runt_writes", 72'(wq.size()), 72'd0);
    chk("runt_frames", 72'(c_frames), 72'd14);
    chk("runt_filt", 72'(c_filt), 72'd7);

    chk("sat_frames", 72'(s_frames), 72'd3);
    chk("sat_accept", 72'(s_accept), 72'd3);
    chk("sat_filt", 72'(s_filt), 72'd3);
    chk("sat_full", 72'(s_full), 72'd1);
    chk("sat_abort", 72'(s_abort), 72'd2);
    chk("sat_tlp", 72'(tlp_cnt_s), 72'd5);

    // Reset in the middle of a TLP: no termination word, engine back to idle
    build(B_NONE, P_MWR);
    for (int k = 0; k < 8; k++) step(aq[k].d, aq[k].c);
    rst = 1'b1;
    step(aq[8].d, aq[8].c);
    rst = 1'b0;
    chk("mrst_wr_en", 72'(wr_en), 72'd0);
    chk("mrst_din", din, 72'd0);
    chk("mrst_frames", 72'(c_frames), 72'd0);
    wq.delete();
    ws.delete();
    for (int k = 9; k < aq.size(); k++) step(aq[k].d, aq[k].c);
    for (int i = 0; i < 10; i++) step(IDLE_D, 8'hFF);
    chk("mrst_writes", 72'(wq.size()), 72'd0);
    chk("mrst_tlp", 72'(tlp_cnt), 72'd0);

    build(B_NONE, P_MWR);
    wq.delete();
    ws.delete();
    send(1'b0, 1'b0, f);
    check_writes(P_MWR, S_MWR, 1'b0, f);
    chk("post_frames", 72'(c_frames), 72'd1);
    chk("post_accept", 72'(c_accept), 72'd1);
    chk("post_tlp", 72'(tlp_cnt), 72'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
